// File: rtl/mem_bist_sweep.sv
// BIST sequencer for a 4096x18 SDP RAM: non-destructive scrub/checksum or fill+verify with mismatch count.
// done at start+4098 (scrub) / start+8195 (fill+verify); no backpressure, start ignored while busy.
module mem_bist_sweep #(
  parameter int WID_MEM   = 18,
  parameter int DEPTH_MEM = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WID_MEM-1:0] seed,
  input  logic [31:0]        exp_sum,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_W:0]    err_count,
  output logic [31:0]        checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SETTLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic               mode;
    logic [WID_MEM-1:0] seed;
    logic [31:0]        exp_sum;
  } cfg_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_MEM - 1);

  state_t              state_q, state_d;
  cfg_t                cfg_q, cfg_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [WID_MEM-1:0]  din_q, din_d;
  logic                fill_wr_q, fill_wr_d;
  logic                chk_vld_q, chk_vld_d;
  logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic [31:0]         sum_q, sum_d;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    raddr_d    = raddr_q;
    waddr_d    = raddr_q;
    din_d      = din_q;
    fill_wr_d  = 1'b0;
    chk_vld_d  = (state_q == S_READ);
    chk_addr_d = raddr_q;
    pass_d     = pass_q;
    err_d      = err_q;
    sum_d      = sum_q;

    // dout carries the word addressed one cycle earlier during READ
    if (chk_vld_q) begin
      if (!cfg_q.mode) begin
        sum_d = sum_q + 32'(mem_dout);
      end else if (mem_dout != (cfg_q.seed + WID_MEM'(chk_addr_q))) begin
        err_d = err_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        raddr_d = '0;
        if (start) begin
          cfg_d  = {mode, seed, exp_sum};
          sum_d  = '0;
          err_d  = '0;
          pass_d = 1'b0;
          if (mode) begin
            state_d   = S_FILL;
            waddr_d   = '0;
            din_d     = seed;
            fill_wr_d = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_FILL: begin
        fill_wr_d = 1'b1;
        if (raddr_q == LAST) begin
          state_d = S_SETTLE;
          waddr_d = LAST;
        end else begin
          raddr_d = raddr_q + 1'b1;
          waddr_d = raddr_q + 1'b1;
          din_d   = din_q + 1'b1;
        end
      end
      S_SETTLE: begin
        state_d = S_READ;
        raddr_d = '0;
      end
      S_READ: begin
        if (raddr_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          raddr_d = raddr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        raddr_d = '0;
        pass_d  = cfg_q.mode ? (err_d == '0) : (sum_d == cfg_q.exp_sum);
      end
      S_DONE: begin
        state_d = S_IDLE;
        raddr_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        raddr_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      din_q      <= '0;
      fill_wr_q  <= 1'b0;
      chk_vld_q  <= 1'b0;
      chk_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
      fill_wr_q  <= fill_wr_d;
      chk_vld_q  <= chk_vld_d;
      chk_addr_q <= chk_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
    end
  end

  // RAM writes every cycle: outside the fill, echo the word just read back to its address
  assign mem_din   = (fill_wr_q && !reset) ? din_q : mem_dout;
  assign mem_raddr = raddr_q;
  assign mem_waddr = waddr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign checksum  = sum_q;

endmodule

// File: doc/mem_bist_sweep.md
# mem_bist_sweep

Sequencer that sits directly in front of the 4096x18 simple-dual-port block RAM (`memory`). It drives the RAM's read address, write address and write data, and consumes its registered read data. It runs one of two sweeps: a non-destructive scrub/checksum of the current contents, or a fill-then-verify pattern test with mismatch counting. The RAM has no write enable and writes every cycle, so this block defines a value-preserving write in every cycle it is not deliberately writing.

## Interface
- `WID_MEM`, 18: RAM word width.
- `DEPTH_MEM`, 4096: RAM depth; must equal 2^`ADDR_W`.
- `ADDR_W`, 12: address width.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a sweep; sampled only in IDLE.
- `mode`  in  1: 0 = scrub/checksum, 1 = fill+verify. Captured at start.
- `seed`  in  `WID_MEM`: fill pattern base. Captured at start.
- `exp_sum`  in  32: expected checksum for mode 0. Captured at start.
- `mem_raddr`  out  `ADDR_W`: to RAM `raddr`.
- `mem_waddr`  out  `ADDR_W`: to RAM `waddr`.
- `mem_din`  out  `WID_MEM`: to RAM `din`.
- `mem_dout`  in  `WID_MEM`: from RAM `dout`, 1-cycle read latency, read-first.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: single-cycle pulse in DONE.
- `pass`  out  1: result flag; valid from `done` until the next start.
- `err_count`  out  `ADDR_W`+1: mode 1 mismatch count.
- `checksum`  out  32: mode 0 running sum.

## Operation
- States: IDLE, FILL, SETTLE, READ, DRAIN, DONE.
- IDLE, with `start`=1: mode 1 goes to FILL and mode 0 goes to READ. Both clear `err_count` and `checksum`, and capture `mode`, `seed` and `exp_sum`.
- FILL (mode 1): runs `DEPTH_MEM` cycles, address a = 0..DEPTH-1.
  - `mem_waddr`=a, `mem_din`=(seed+a) mod 2^WID_MEM, `mem_raddr`=a.
  - After a = DEPTH-1, go to SETTLE.
- SETTLE: one cycle. `mem_waddr`=`mem_raddr`=DEPTH-1, `mem_din`=pattern(DEPTH-1). This refreshes dout with post-fill data. Go to READ.
- Write-back rule (all states except FILL and SETTLE): `mem_waddr`=`mem_raddr` of the previous cycle, and `mem_din`=`mem_dout` passed through combinationally. Each write therefore rewrites the value just read.
- READ: runs `DEPTH_MEM` cycles with `mem_raddr`=0..DEPTH-1, then goes to DRAIN.
- Data check: in each cycle where `mem_dout` holds the data for address a (READ cycles 2..DEPTH, plus DRAIN):
  - mode 0: `checksum` += zero-extended `mem_dout`, mod 2^32.
  - mode 1: `err_count` += 1 when `mem_dout` ≠ (seed+a) mod 2^WID_MEM.
- DRAIN: one cycle; `mem_raddr` holds DEPTH-1; processes the last word. Go to DONE.
- DONE: one cycle with `done`=1, then IDLE.
  - mode 0: `pass`=(checksum==exp_sum).
  - mode 1: `pass`=(err_count==0).
- IDLE: `mem_raddr`=0. `checksum`, `err_count` and `pass` hold their values.
- `start` outside IDLE is ignored. `start` in DONE is also ignored.
- `err_count` cannot overflow: its maximum is DEPTH, which fits in `ADDR_W`+1 bits.

## Timing
- Reset values: state IDLE, `mem_raddr`=0, `mem_waddr`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `checksum`=0.
- During reset, `mem_din`=`mem_dout`.
- The first reset cycle may rewrite word 0 with stale dout. The bench holds reset for at least 2 cycles.
- Mode 0 cycle timeline (T = cycle `start` is sampled):
  - READ T+1..T+DEPTH, DRAIN T+DEPTH+1.
  - `done` at T+DEPTH+2, i.e. T+4098.
- Mode 1 cycle timeline:
  - FILL T+1..T+DEPTH, SETTLE T+DEPTH+1.
  - READ T+DEPTH+2..T+2·DEPTH+1, DRAIN T+2·DEPTH+2.
  - `done` at T+2·DEPTH+3, i.e. T+8195.
- Reset mid-sweep: IDLE on the next cycle, all outputs return to reset values, and `done` does not pulse. RAM contents are unspecified after a partial FILL and unchanged after a partial READ.

## Test plan
- Mode 1, seed=0: `done` at T+8195, `err_count`=0, `pass`=1. A following mode 0 sweep gives `checksum`=0x007FF800 (sum of 0..4095).
- Mode 1, seed=0x3FFF0: word 16 reads 0x00000 (wrap) and word 15 reads 0x3FFFF; `err_count`=0.
- Mode 1, with the bench forcing `mem_dout` bit 0 on the cycle that carries address 5's data: `err_count`=1, `pass`=0.
- Mode 0 run twice back-to-back on the init-file contents: identical `checksum` both times. With exp_sum set to that value, `pass`=1. RAM is unchanged (verified by backdoor compare).
- Reset asserted at FILL cycle 100: `busy`=0 the next cycle and no `done` pulse. A new mode 1 sweep then passes.
- `start` held high for the whole mode 0 sweep: exactly one `done`. A second sweep starts the cycle after DONE returns to IDLE.
